// File: rtl/doc_uart_sender_pkg.sv
// Shared constants and FSM encodings for the document UART dump path.
package doc_uart_sender_pkg;

    localparam logic [7:0] UART_CR    = 8'h0D;
    localparam logic [7:0] UART_LF    = 8'h0A;
    localparam logic [7:0] UART_SPACE = 8'h20;

    localparam int unsigned TEXT_ROWS = 15;
    localparam int unsigned TEXT_COLS = 20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_CR,
        ST_LF,
        ST_SEND,
        ST_WAIT,
        ST_CLEAR
    } state_t;

    // What the byte in flight was, so the wait state knows where to go next.
    typedef enum logic [1:0] {
        KIND_DATA,
        KIND_CR,
        KIND_LF
    } byte_kind_t;

endpackage

// File: rtl/doc_uart_sender_tx.sv
// 8N1 byte transmitter: one load pulse starts a frame, done marks the last stop-bit cycle.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] STOP_IDX  = 4'd9;

    logic       active;
    logic [7:0] baud_cnt;
    logic [3:0] bit_idx;
    logic [7:0] shift;
    logic       bit_end;

    assign bit_end = active && (baud_cnt == BAUD_LAST);
    assign done    = bit_end && (bit_idx == STOP_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else if (!active) begin
            if (load) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shift    <= data;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
                active  <= 1'b0;
                bit_idx <= '0;
            end else begin
                // Indices 0..7 hand out data bits LSB first; leaving index 8 drives the stop bit.
                bit_idx <= bit_idx + 4'd1;
                tx      <= (bit_idx < 4'd8) ? shift[0] : 1'b1;
                shift   <= {1'b1, shift[7:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/doc_uart_sender.sv
// Streams the whole text document over UART row by row with CR LF, then pulses clear_data.
module doc_uart_sender
    import doc_uart_sender_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned ROWS     = TEXT_ROWS,
    parameter int unsigned COLS     = TEXT_COLS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_start,
    output logic       read_enable,
    output logic [9:0] read_addr,
    input  logic [7:0] read_data,
    output logic       clear_data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [3:0]  LAST_ROW     = 4'(ROWS - 1);
    localparam logic [4:0]  LAST_COL     = 5'(COLS - 1);

    state_t     state, state_next;
    byte_kind_t kind;
    logic [3:0] row;
    logic [4:0] col;
    logic [7:0] tx_byte;
    logic       load;
    logic       tx_done;

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .data (tx_byte),
        .tx   (tx),
        .done (tx_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            ST_IDLE:  if (send_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: state_next = ST_SEND;
            ST_CR:    state_next = ST_SEND;
            ST_LF:    state_next = ST_SEND;
            ST_SEND: begin
                load       = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done) begin
                    case (kind)
                        KIND_DATA: state_next = (col == LAST_COL) ? ST_CR : ST_FETCH;
                        KIND_CR:   state_next = ST_LF;
                        default:   state_next = (row == LAST_ROW) ? ST_CLEAR : ST_FETCH;
                    endcase
                end
            end
            ST_CLEAR: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // CR/LF are staged through tx_byte like data so every byte shares the SEND/WAIT pair.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row     <= '0;
            col     <= '0;
            tx_byte <= '0;
            kind    <= KIND_DATA;
        end else begin
            case (state)
                ST_IDLE: if (send_start) begin
                    row <= '0;
                    col <= '0;
                end
                ST_LATCH: begin
                    tx_byte <= (read_data == 8'h00) ? UART_SPACE : read_data;
                    kind    <= KIND_DATA;
                end
                ST_CR: begin
                    tx_byte <= UART_CR;
                    kind    <= KIND_CR;
                end
                ST_LF: begin
                    tx_byte <= UART_LF;
                    kind    <= KIND_LF;
                end
                ST_WAIT: if (tx_done) begin
                    if (kind == KIND_DATA && col != LAST_COL) begin
                        col <= col + 5'd1;
                    end else if (kind == KIND_LF && row != LAST_ROW) begin
                        row <= row + 4'd1;
                        col <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign read_enable = (state != ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign clear_data  = (state == ST_CLEAR);
    assign read_addr   = {1'b0, row, col};

endmodule

// File: tb/tb_doc_uart_sender.sv
// Directed bench: full-rate instance for bit timing and reset, fast-baud instance for whole dumps.
module tb_doc_uart_sender;

    localparam int unsigned SLOW_CPB = 217;
    localparam int unsigned FAST_CPB = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_slow, start_fast;
    logic       ren_slow, ren_fast;
    logic [9:0] addr_slow, addr_fast;
    logic [7:0] rd_slow, rd_fast;
    logic       clear_slow, clear_fast;
    logic       busy_slow, busy_fast;
    logic       tx_slow, tx_fast;

    logic [7:0] doc_slow [0:1023];
    logic [7:0] doc_fast [0:1023];
    assign rd_slow = doc_slow[addr_slow];
    assign rd_fast = doc_fast[addr_fast];

    doc_uart_sender dut_slow (
        .clk(clk), .rst(rst), .send_start(start_slow), .read_enable(ren_slow),
        .read_addr(addr_slow), .read_data(rd_slow), .clear_data(clear_slow),
        .busy(busy_slow), .tx(tx_slow)
    );

    doc_uart_sender #(.CLK_FREQ(FAST_CPB), .BAUD(1)) dut_fast (
        .clk(clk), .rst(rst), .send_start(start_fast), .read_enable(ren_fast),
        .read_addr(addr_fast), .read_data(rd_fast), .clear_data(clear_fast),
        .busy(busy_fast), .tx(tx_fast)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Receiver model for the fast line, sampling mid-bit on negative clock edges.
    logic [7:0]  rx_q [$];
    int unsigned frame_err = 0;
    initial begin : rx_model
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge tx_fast);
            repeat (3) @(negedge clk);
            if (tx_fast !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (FAST_CPB) @(negedge clk);
                b[i] = tx_fast;
            end
            repeat (FAST_CPB) @(negedge clk);
            if (tx_fast !== 1'b1) frame_err++;
            rx_q.push_back(b);
        end
    end

    // Address / clear monitor for the fast instance.
    logic        mon_reset = 1'b0;
    logic        clear_prev = 1'b0;
    logic [10:0] last_addr = 11'h7FF;
    int unsigned clear_pulses = 0, clear_cycles = 0, bad_addr = 0, addr_changes = 0;
    int unsigned visits [0:1023];
    always @(negedge clk) begin
        if (mon_reset) begin
            clear_pulses = 0;
            clear_cycles = 0;
            bad_addr     = 0;
            addr_changes = 0;
            last_addr    = 11'h7FF;
            foreach (visits[i]) visits[i] = 0;
        end else begin
            if (clear_fast) clear_cycles++;
            if (clear_fast && !clear_prev) clear_pulses++;
            if (ren_fast) begin
                if (addr_fast[9] || addr_fast[4:0] >= 5'd20 || addr_fast[8:5] >= 4'd15) bad_addr++;
                if ({1'b0, addr_fast} != last_addr) begin
                    visits[addr_fast]++;
                    addr_changes++;
                    last_addr = {1'b0, addr_fast};
                end
            end else begin
                last_addr = 11'h7FF;
            end
        end
        clear_prev = clear_fast;
    end

    task automatic fast_dump(input bit zero_doc, input bit extra_req);
        int unsigned base, n, idx, bad_cells;
        logic [7:0]  exp;
        for (int unsigned r = 0; r < 15; r++)
            for (int unsigned c = 0; c < 20; c++)
                doc_fast[10'(r * 32 + c)] = zero_doc ? 8'h00 : 8'(32'h30 + c % 10);
        base = 32'(rx_q.size());
        mon_reset = 1'b1;
        repeat (2) @(negedge clk);
        mon_reset = 1'b0;
        start_fast = 1'b1;
        @(negedge clk);
        start_fast = 1'b0;
        check_eq("fast busy after start", 32'(busy_fast), 32'd1);
        if (extra_req) begin
            n = 0;
            while (32'(rx_q.size()) < base + 100 && n < 20000) begin
                @(negedge clk);
                n++;
            end
            check_eq("reached byte 100", 32'(n < 20000), 32'd1);
            check_eq("busy at byte 100", 32'(busy_fast), 32'd1);
            start_fast = 1'b1;
            @(negedge clk);
            start_fast = 1'b0;
        end
        n = 0;
        while (clear_fast !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check_eq("clear seen", 32'(clear_fast), 32'd1);
        check_eq("busy during clear", 32'(busy_fast), 32'd1);
        @(negedge clk);
        check_eq("busy after clear", 32'(busy_fast), 32'd0);
        check_eq("ren after clear", 32'(ren_fast), 32'd0);
        repeat (300) @(negedge clk);
        check_eq("idle after dump", 32'(busy_fast), 32'd0);
        check_eq("byte count", 32'(rx_q.size()) - base, 32'd330);
        check_eq("clear pulses", clear_pulses, 32'd1);
        check_eq("clear width", clear_cycles, 32'd1);
        check_eq("bad addresses", bad_addr, 32'd0);
        check_eq("address changes", addr_changes, 32'd300);
        bad_cells = 0;
        for (int unsigned r = 0; r < 15; r++)
            for (int unsigned c = 0; c < 20; c++)
                if (visits[r * 32 + c] != 1) bad_cells++;
        check_eq("cells not visited once", bad_cells, 32'd0);
        check_eq("frame errors", frame_err, 32'd0);
        idx = base;
        for (int unsigned r = 0; r < 15; r++) begin
            for (int unsigned c = 0; c < 22; c++) begin
                if (c == 20)      exp = 8'h0D;
                else if (c == 21) exp = 8'h0A;
                else              exp = zero_doc ? 8'h20 : 8'(32'h30 + c % 10);
                if (idx < 32'(rx_q.size()))
                    check_eq($sformatf("byte r%0d c%0d", r, c), 32'(rx_q[idx]), 32'(exp));
                idx++;
            end
        end
    endtask

    initial begin
        int unsigned n, bad;
        logic [9:0]  pat;
        pat = 10'b1010000010;
        foreach (doc_slow[i]) doc_slow[i] = 8'h00;
        foreach (doc_fast[i]) doc_fast[i] = 8'h00;
        doc_slow[0] = 8'h41;
        rst = 1'b0;
        start_slow = 1'b0;
        start_fast = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset tx", 32'(tx_slow), 32'd1);
        check_eq("reset busy", 32'(busy_slow), 32'd0);
        check_eq("reset ren", 32'(ren_slow), 32'd0);
        check_eq("reset clear", 32'(clear_slow), 32'd0);
        check_eq("reset addr", 32'(addr_slow), 32'd0);
        check_eq("reset fast tx", 32'(tx_fast), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Bit timing of 'A' at 217 clocks per bit.
        start_slow = 1'b1;
        @(negedge clk);
        start_slow = 1'b0;
        n = 0;
        while (tx_slow !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("start bit found", 32'(n < 50), 32'd1);
        for (int i = 0; i < 10 * SLOW_CPB; i++) begin
            if (i % SLOW_CPB == 0)
                check_eq($sformatf("bit%0d first cycle", i / SLOW_CPB), 32'(tx_slow), 32'(pat[i / SLOW_CPB]));
            if (i % SLOW_CPB == SLOW_CPB - 1)
                check_eq($sformatf("bit%0d last cycle", i / SLOW_CPB), 32'(tx_slow), 32'(pat[i / SLOW_CPB]));
            @(negedge clk);
        end
        check_eq("line high after stop", 32'(tx_slow), 32'd1);
        check_eq("next cell address", 32'(addr_slow), 32'd1);
        check_eq("busy mid dump", 32'(busy_slow), 32'd1);

        // Asynchronous reset in the middle of the second frame.
        n = 0;
        while (tx_slow !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("second start found", 32'(n < 50), 32'd1);
        repeat (300) @(negedge clk);
        check_eq("mid frame data bit", 32'(tx_slow), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("async rst tx", 32'(tx_slow), 32'd1);
        check_eq("async rst busy", 32'(busy_slow), 32'd0);
        check_eq("async rst ren", 32'(ren_slow), 32'd0);
        check_eq("async rst addr", 32'(addr_slow), 32'd0);
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (tx_slow !== 1'b1 || busy_slow !== 1'b0) bad++;
        end
        check_eq("held reset idle", bad, 32'd0);
        rst = 1'b1;
        bad = 0;
        repeat (3000) begin
            @(negedge clk);
            if (tx_slow !== 1'b1 || busy_slow !== 1'b0 || ren_slow !== 1'b0) bad++;
        end
        check_eq("idle after release", bad, 32'd0);

        fast_dump(1'b0, 1'b1);
        fast_dump(1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
